// File: rtl/regression_accumulator3x3.sv
// regression_accumulator3x3
// Streaming front end of the 3x3 regression solver. Each accepted (x, y)
// sample in signed fixed point is expanded to the quadratic basis
// phi = [1, x, x^2]. The block accumulates the normal equations
// A = sum(phi*phi^T) and B = sum(phi*y), then presents them saturated to
// WIDTH with a one-cycle out_valid pulse when the batch ends.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_valid/ready  input handshake for x, y, sample_last
//   x, y                signed Q(QINT).(QFRAC) regressor and response
//   sample_last         final sample of the batch
//   out_valid           one-cycle pulse, A_flat/B_flat updated
//   A_flat              9 words, element i at [i*WIDTH +: WIDTH], row-major
//   B_flat              3 words {Sy, Sxy, Sx2y}, element i at [i*WIDTH +: WIDTH]
//   sat_flag            only with REGACC_SAT_FLAG_EN: some saturation hit
//                       during the batch reported with this out_valid
//
// Handshake: a sample moves when sample_valid && sample_ready at a rising
// clk edge. The source holds x/y/sample_last stable until that happens;
// sample_ready never depends on sample_valid.
//
// Optional build macro: REGACC_SAT_FLAG_EN adds the sat_flag output and the
// saturation-detect logic behind it.
//
// Debug: the FSM state is held in state_q (type state_t) for bound checkers.
module regression_accumulator3x3 #(
  parameter int WIDTH     = 32,
  parameter int QINT      = 16,
  parameter int QFRAC     = WIDTH - QINT,
  parameter int ACC_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [WIDTH-1:0]       x,
  input  logic [WIDTH-1:0]       y,
  input  logic                   sample_last,
  output logic                   out_valid,
  output logic [9*WIDTH-1:0]     A_flat,
  output logic [3*WIDTH-1:0]     B_flat
`ifdef REGACC_SAT_FLAG_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int MW = 2 * WIDTH;
  localparam int PW = 2 * ACC_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ONE_Q   = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << QFRAC;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;
  state_t state_q, state_d;

  // Full-precision product clamped to ACC_WIDTH before the Q shift.
  function automatic logic signed [ACC_WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
    if (v[PW-1:ACC_WIDTH-1] == {(PW-ACC_WIDTH+1){v[PW-1]}}) return v[ACC_WIDTH-1:0];
    return v[PW-1] ? ACC_MIN : ACC_MAX;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                          input logic signed [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
    if (v[ACC_WIDTH-1:WIDTH-1] == {(ACC_WIDTH-WIDTH+1){v[ACC_WIDTH-1]}}) return v[WIDTH-1:0];
    return v[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Pipeline stage registers
  logic                        v1, v2, v3;
  logic signed [WIDTH-1:0]     x_s1, y_s1, x_s2, y_s2, x_s3, y_s3;
  logic signed [ACC_WIDTH-1:0] x2_s2, xy_s2;
  logic signed [ACC_WIDTH-1:0] x2_s3, xy_s3, x3_s3, x4_s3, x2y_s3;

  // Accumulators: 0 N, 1 Sx, 2 Sx2, 3 Sx3, 4 Sx4, 5 Sy, 6 Sxy, 7 Sx2y
  logic signed [ACC_WIDTH-1:0] acc_q  [8];
  logic signed [ACC_WIDTH-1:0] acc_in [8];

  logic signed [MW-1:0] m_xx, m_xy;
  logic signed [PW-1:0] p_xx, p_xy, p_x3, p_x4, p_x2y;
  logic accept;

  // ---------------- FSM ----------------
  always_comb begin
    state_d      = state_q;
    sample_ready = 1'b0;
    accept       = 1'b0;
    sample_ready = rst_n && (state_q == IDLE || state_q == ACCUM);
    accept       = sample_valid && sample_ready;
    case (state_q)
      IDLE:  if (accept) state_d = sample_last ? DRAIN : ACCUM;
      ACCUM: if (accept && sample_last) state_d = DRAIN;
      // S3 content is absorbed by the accumulators on this same edge, so
      // EMIT only needs S1/S2 empty to see the final sums.
      DRAIN: if (!v1 && !v2) state_d = EMIT;
      EMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- product datapath ----------------
  always_comb begin
    m_xx  = MW'(x_s1) * MW'(x_s1);
    m_xy  = MW'(x_s1) * MW'(y_s1);
    p_xx  = PW'(m_xx);
    p_xy  = PW'(m_xy);
    p_x3  = PW'(x2_s2) * PW'(x_s2);
    p_x4  = PW'(x2_s2) * PW'(x2_s2);
    p_x2y = PW'(x2_s2) * PW'(y_s2);
    acc_in[0] = ONE_Q;
    acc_in[1] = {{(ACC_WIDTH-WIDTH){x_s3[WIDTH-1]}}, x_s3};
    acc_in[2] = x2_s3;
    acc_in[3] = x3_s3;
    acc_in[4] = x4_s3;
    acc_in[5] = {{(ACC_WIDTH-WIDTH){y_s3[WIDTH-1]}}, y_s3};
    acc_in[6] = xy_s3;
    acc_in[7] = x2y_s3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      x_s1 <= '0; y_s1 <= '0; x_s2 <= '0; y_s2 <= '0; x_s3 <= '0; y_s3 <= '0;
      x2_s2 <= '0; xy_s2 <= '0;
      x2_s3 <= '0; xy_s3 <= '0; x3_s3 <= '0; x4_s3 <= '0; x2y_s3 <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) begin
        x_s1 <= x;
        y_s1 <= y;
      end
      if (v1) begin
        x_s2  <= x_s1;
        y_s2  <= y_s1;
        x2_s2 <= sat_prod(p_xx) >>> QFRAC;
        xy_s2 <= sat_prod(p_xy) >>> QFRAC;
      end
      if (v2) begin
        x_s3   <= x_s2;
        y_s3   <= y_s2;
        x2_s3  <= x2_s2;
        xy_s3  <= xy_s2;
        x3_s3  <= sat_prod(p_x3) >>> QFRAC;
        x4_s3  <= sat_prod(p_x4) >>> QFRAC;
        x2y_s3 <= sat_prod(p_x2y) >>> QFRAC;
      end
    end
  end

  // ---------------- accumulate and emit ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) acc_q[k] <= '0;
      out_valid <= 1'b0;
      A_flat    <= '0;
      B_flat    <= '0;
    end else begin
      out_valid <= (state_q == EMIT);
      if (state_q == EMIT) begin
        A_flat <= {sat_out(acc_q[4]), sat_out(acc_q[3]), sat_out(acc_q[2]),
                   sat_out(acc_q[3]), sat_out(acc_q[2]), sat_out(acc_q[1]),
                   sat_out(acc_q[2]), sat_out(acc_q[1]), sat_out(acc_q[0])};
        B_flat <= {sat_out(acc_q[7]), sat_out(acc_q[6]), sat_out(acc_q[5])};
        for (int k = 0; k < 8; k++) acc_q[k] <= '0;
      end else if (v3) begin
        for (int k = 0; k < 8; k++) acc_q[k] <= sat_add(acc_q[k], acc_in[k]);
      end
    end
  end

`ifdef REGACC_SAT_FLAG_EN
  function automatic logic ovf_prod(input logic signed [PW-1:0] v);
    return v[PW-1:ACC_WIDTH-1] != {(PW-ACC_WIDTH+1){v[PW-1]}};
  endfunction

  function automatic logic ovf_add(input logic signed [ACC_WIDTH-1:0] a,
                                   input logic signed [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    return s[ACC_WIDTH] != s[ACC_WIDTH-1];
  endfunction

  function automatic logic ovf_out(input logic signed [ACC_WIDTH-1:0] v);
    return v[ACC_WIDTH-1:WIDTH-1] != {(ACC_WIDTH-WIDTH+1){v[ACC_WIDTH-1]}};
  endfunction

  logic sat_sticky, sat_hit, out_ovf;

  always_comb begin
    sat_hit = 1'b0;
    out_ovf = 1'b0;
    if (v1) sat_hit = sat_hit | ovf_prod(p_xx) | ovf_prod(p_xy);
    if (v2) sat_hit = sat_hit | ovf_prod(p_x3) | ovf_prod(p_x4) | ovf_prod(p_x2y);
    if (v3) for (int k = 0; k < 8; k++) sat_hit = sat_hit | ovf_add(acc_q[k], acc_in[k]);
    for (int k = 0; k < 8; k++) out_ovf = out_ovf | ovf_out(acc_q[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
      sat_flag   <= 1'b0;
    end else if (state_q == EMIT) begin
      sat_flag   <= sat_sticky | sat_hit | out_ovf;
      sat_sticky <= 1'b0;
    end else begin
      sat_sticky <= sat_sticky | sat_hit;
    end
  end
`endif

endmodule

// File: tb/tb_regression_accumulator3x3.sv
// Testbench for regression_accumulator3x3: directed batches with known
// sums, saturation, bubbles/backpressure, mid-batch reset and short random
// batches. Expected results are queued when a batch's last sample is
// accepted and compared when out_valid pulses.
module tb_regression_accumulator3x3;

  localparam int W     = 32;
  localparam int EXP_W = 12 * W + 1;  // 9 A words, 3 B words, sat bit on top

  logic            clk;
  logic            rst_n;
  logic            sample_valid;
  logic            sample_ready;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic            sample_last;
  logic            out_valid;
  logic [9*W-1:0]  A_flat;
  logic [3*W-1:0]  B_flat;
`ifdef REGACC_SAT_FLAG_EN
  logic            sat_flag;
`endif

  regression_accumulator3x3 dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .x(x),
    .y(y),
    .sample_last(sample_last),
    .out_valid(out_valid),
    .A_flat(A_flat),
    .B_flat(B_flat)
`ifdef REGACC_SAT_FLAG_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               lat_q[$];
  logic [W-1:0]     bx[$];
  logic [W-1:0]     by[$];
  logic [EXP_W-1:0] pending_exp;
  bit               pending_valid = 0;
  int               last_waits;
  int               n_checks = 0;
  int               n_errors = 0;
  bit               m_sat;
  bit               prev_ov = 0;
  int               amap [9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] ext(input logic signed [63:0] v);
    return {{64{v[63]}}, v};
  endfunction

  function automatic logic signed [63:0] m_sat64(input logic signed [127:0] v);
    if (v > 128'sh7FFF_FFFF_FFFF_FFFF) begin
      m_sat = 1'b1;
      return 64'sh7FFF_FFFF_FFFF_FFFF;
    end
    if (v < -128'sh8000_0000_0000_0000) begin
      m_sat = 1'b1;
      return 64'sh8000_0000_0000_0000;
    end
    return v[63:0];
  endfunction

  function automatic logic signed [63:0] m_prod(input logic signed [63:0] a, input logic signed [63:0] b);
    logic signed [127:0] p;
    logic signed [63:0]  s;
    p = ext(a) * ext(b);
    s = m_sat64(p);
    return s >>> 16;
  endfunction

  function automatic logic [31:0] m_sat32(input logic signed [63:0] v);
    if (v > 64'sh7FFF_FFFF) begin
      m_sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (v < -64'sh8000_0000) begin
      m_sat = 1'b1;
      return 32'h8000_0000;
    end
    return v[31:0];
  endfunction

  function automatic logic [EXP_W-1:0] model();
    logic signed [63:0] acc [8];
    logic signed [63:0] t   [8];
    logic signed [63:0] xv, yv, x2;
    logic [EXP_W-1:0]   e;
    m_sat = 1'b0;
    for (int k = 0; k < 8; k++) acc[k] = '0;
    for (int i = 0; i < bx.size(); i++) begin
      xv   = {{32{bx[i][31]}}, bx[i]};
      yv   = {{32{by[i][31]}}, by[i]};
      x2   = m_prod(xv, xv);
      t[0] = 64'sh10000;
      t[1] = xv;
      t[2] = x2;
      t[3] = m_prod(x2, xv);
      t[4] = m_prod(x2, x2);
      t[5] = yv;
      t[6] = m_prod(xv, yv);
      t[7] = m_prod(x2, yv);
      for (int k = 0; k < 8; k++) acc[k] = m_sat64(ext(acc[k]) + ext(t[k]));
    end
    e = '0;
    for (int j = 0; j < 9; j++) e[j*W +: W] = m_sat32(acc[amap[j]]);
    for (int j = 0; j < 3; j++) e[(9+j)*W +: W] = m_sat32(acc[5+j]);
    e[EXP_W-1] = m_sat;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic last);
    bit ok;
    x = xv; y = yv; sample_last = last; sample_valid = 1'b1;
    last_waits = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_ready) begin ok = 1'b1; break; end
      last_waits++;
      if (last_waits >= 200) begin check("accept_timeout", 64'(last_waits), 64'd0); break; end
    end
    if (ok) begin
      bx.push_back(xv);
      by.push_back(yv);
      if (last) begin
        exp_q.push_back(pending_valid ? pending_exp : model());
        pending_valid = 1'b0;
        bx.delete();
        by.delete();
      end
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_const(input logic [EXP_W-1:0] e);
    pending_exp   = e;
    pending_valid = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_q();
    return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    int lc;
    if (rst_n && out_valid) begin
      check("ov_pulse_width", 64'(prev_ov), 64'd0);
      check("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 9; i++)
          check($sformatf("A_flat[%0d]", i), 64'(A_flat[i*W +: W]), 64'(e[i*W +: W]));
        for (int i = 0; i < 3; i++)
          check($sformatf("B_flat[%0d]", i), 64'(B_flat[i*W +: W]), 64'(e[(9+i)*W +: W]));
`ifdef REGACC_SAT_FLAG_EN
        check("sat_flag", 64'(sat_flag), 64'(e[EXP_W-1]));
`endif
      end
      if (lat_q.size() != 0) begin
        lc = lat_q.pop_front();
        check("latency", 64'(cyc - lc), 64'd5);
      end
    end
    if (rst_n && sample_valid && sample_ready && sample_last) lat_q.push_back(cyc);
    prev_ov = out_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b1;
    x = $urandom;
    y = $urandom;
    sample_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sample_ready", 64'(sample_ready), 64'd0);
    for (int i = 0; i < 9; i++) check($sformatf("rst_A[%0d]", i), 64'(A_flat[i*W +: W]), 64'd0);
    for (int i = 0; i < 3; i++) check($sformatf("rst_B[%0d]", i), 64'(B_flat[i*W +: W]), 64'd0);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(sample_ready), 64'd1);
    @(posedge clk); #1;

    // Batch x={1,2,3}, y={2,4,6}
    expect_const({1'b0, 32'h48_0000, 32'h1C_0000, 32'h0C_0000,
                  32'h62_0000, 32'h24_0000, 32'h0E_0000, 32'h24_0000, 32'h0E_0000,
                  32'h06_0000, 32'h0E_0000, 32'h06_0000, 32'h03_0000});
    send(32'h1_0000, 32'h2_0000, 1'b0);
    send(32'h2_0000, 32'h4_0000, 1'b0);
    send(32'h3_0000, 32'h6_0000, 1'b1);
    wait_drain();

    // Single sample x=0.5, y=-1
    expect_const({1'b0, 32'hFFFF_C000, 32'hFFFF_8000, 32'hFFFF_0000,
                  32'h1000, 32'h2000, 32'h4000, 32'h2000, 32'h4000,
                  32'h8000, 32'h4000, 32'h8000, 32'h1_0000});
    send(32'h0000_8000, 32'hFFFF_0000, 1'b1);
    wait_drain();

    // Saturation: x=200, y=1
    expect_const({1'b1, 32'h7FFF_FFFF, 32'h00C8_0000, 32'h0001_0000,
                  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                  32'h00C8_0000, 32'h7FFF_FFFF, 32'h00C8_0000, 32'h0001_0000});
    send(32'h00C8_0000, 32'h0001_0000, 1'b1);
    wait_drain();

    // Bubbles, then a sample held through DRAIN/EMIT into the next batch
    expect_const({1'b0, 32'h48_0000, 32'h1C_0000, 32'h0C_0000,
                  32'h62_0000, 32'h24_0000, 32'h0E_0000, 32'h24_0000, 32'h0E_0000,
                  32'h06_0000, 32'h0E_0000, 32'h06_0000, 32'h03_0000});
    send(32'h1_0000, 32'h2_0000, 1'b0);
    idle(1);
    send(32'h2_0000, 32'h4_0000, 1'b0);
    idle(1);
    send(32'h3_0000, 32'h6_0000, 1'b1);
    send(32'h2_0000, 32'h1_0000, 1'b0);
    check("drain_hold_waits", 64'(last_waits), 64'd4);
    send(32'h3_0000, 32'hFFFF_0000, 1'b1);
    wait_drain();

    // Short random batches
    for (int b = 0; b < 3; b++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        send(rnd_q(), rnd_q(), (i == n - 1));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
    end
    wait_drain();

    // Reset mid-batch discards partial sums
    send(32'h5_0000, 32'h7_0000, 1'b0);
    send(32'h6_0000, 32'h9_0000, 1'b0);
    rst_n = 1'b0;
    bx.delete();
    by.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sample_ready", 64'(sample_ready), 64'd0);
    check("midrst_A0", 64'(A_flat[0 +: W]), 64'd0);
    check("midrst_B0", 64'(B_flat[0 +: W]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    expect_const({1'b0, {12{32'h1_0000}}});
    send(32'h1_0000, 32'h1_0000, 1'b1);
    wait_drain();
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regression_accumulator3x3.md
Name: regression_accumulator3x3

Overview:
- Streaming producer for the 3x3 pipelined regression solver.
- Consumes a batch of (x, y) path samples in Q16.16 and builds the quadratic basis phi = [1, x, x^2].
- Accumulates the normal equations A = sum(phi·phi^T) and B = sum(phi·y).
- At end of batch, emits A_flat[0:8] and B_flat[0:2] with a one-cycle valid pulse, in the format the solver's valid_in/A_flat/B_flat inputs take.

Parameters:
- WIDTH, 32, sample and output word width (signed fixed point)
- QINT, 16, integer bits of the I/O format
- QFRAC, WIDTH-QINT, fraction bits of the I/O format
- ACC_WIDTH, 64, signed width of internal power registers and accumulators; each carries QFRAC fraction bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  x/y/sample_last valid this cycle
- sample_ready  out  1  block accepts a sample this cycle
- x  in  WIDTH  signed Q16.16 regressor (underlying price)
- y  in  WIDTH  signed Q16.16 response (discounted cash flow)
- sample_last  in  1  marks the final sample of the batch
- out_valid  out  1  one-cycle pulse: A_flat/B_flat hold a new result
- A_flat  out  9xWIDTH  row-major normal matrix, signed Q16.16
- B_flat  out  3xWIDTH  right-hand side, signed Q16.16

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block has one clock, clk.
- While rst_n is low:
  - out_valid = 0, A_flat = 0, B_flat = 0.
  - All accumulators, pipeline valids and the sample counter clear.
  - FSM goes to IDLE.
- sample_ready = 1 in IDLE and ACCUM; 0 in DRAIN and EMIT.
- A sample is accepted when sample_valid && sample_ready.
- FSM:
  - IDLE: on accept, go to ACCUM. If sample_last is set on that accept, go directly to DRAIN.
  - ACCUM: on accept with sample_last=1, go to DRAIN.
  - DRAIN: wait until the product pipeline is empty (all stage valids low), then go to EMIT.
  - EMIT: for one cycle, register saturated sums onto the outputs, pulse out_valid, clear accumulators and counter. Next state is IDLE.
- Product pipeline (3 stages, each with its own valid bit, registered at every stage):
  - S1: register x, y.
  - S2: x2 = (x*x)>>>QFRAC and xy = (x*y)>>>QFRAC, held at ACC_WIDTH.
  - S3: x3 = (x2*x)>>>QFRAC, x4 = (x2*x2)>>>QFRAC, x2y = (x2*y)>>>QFRAC, held at ACC_WIDTH. Each full-precision product saturates to ACC_WIDTH before the shift.
  - S4 (accumulate): N += 1<<QFRAC; Sx += x; Sx2 += x2; Sx3 += x3; Sx4 += x4; Sy += y; Sxy += xy; Sx2y += x2y.
- Rounding: arithmetic right shift (floor toward -inf) on every product.
- Accumulators saturate at ACC_WIDTH signed bounds and never wrap.
- Output mapping, each value saturated to WIDTH (0x7FFF_FFFF / 0x8000_0000):
  - A_flat[0]=N
  - A_flat[1]=A_flat[3]=Sx
  - A_flat[2]=A_flat[4]=A_flat[6]=Sx2
  - A_flat[5]=A_flat[7]=Sx3
  - A_flat[8]=Sx4
  - B_flat = {Sy, Sxy, Sx2y}
- Latency: out_valid rises exactly 5 cycles after the cycle in which sample_last is accepted (S1, S2, S3, S4, EMIT).
- A_flat/B_flat hold their values after the pulse until the next EMIT.
- Back-to-back batches: a new batch's first sample is accepted the cycle after EMIT (IDLE).
- sample_valid deasserted mid-batch: pipeline bubbles are allowed; partial sums are retained indefinitely.
- sample_valid while sample_ready=0: ignored. The source must hold the sample until it is accepted.
- Reset mid-batch: the partial batch is discarded and no out_valid is produced.
- No empty batch exists: sample_last always accompanies a sample, so N >= 1.

Optional Feature:
- Macro REGACC_SAT_FLAG_EN.
- When defined:
  - Adds output port sat_flag (1 bit, reset 0).
  - sat_flag is set if any product, accumulator or output saturation occurred during the batch.
  - It updates together with out_valid and holds with the outputs.
  - The internal sticky bit clears at EMIT.
- When undefined: no port and no saturation-detect logic. The datapath is otherwise identical.

Test Plan:
- Reset check: hold rst_n=0 with sample_valid=1 -> out_valid=0, sample_ready=0, all outputs 0. After release, sample_ready=1.
- Batch x={1,2,3}, y={2,4,6}, last on 3rd sample -> after 5 cycles, out_valid=1 for one cycle.
  - A_flat = {0x30000, 0x60000, 0xE0000, 0x60000, 0xE0000, 0x240000, 0xE0000, 0x240000, 0x620000}.
  - B_flat = {0xC0000, 0x1C0000, 0x480000}.
- Single sample x=0x8000 (0.5), y=0xFFFF0000 (-1) with last -> A_flat = {0x10000, 0x8000, 0x4000, 0x8000, 0x4000, 0x2000, 0x4000, 0x2000, 0x1000}; B_flat = {0xFFFF0000, 0xFFFF8000, 0xFFFFC000}.
- Saturation: single sample x=200.0 (0x00C80000), y=1.0 -> A_flat[8], A_flat[5], A_flat[7] = 0x7FFF_FFFF; A_flat[2] = 0x7FFF_FFFF (40000 > 32767); B_flat[2] = 0x7FFF_FFFF. With REGACC_SAT_FLAG_EN defined, sat_flag=1.
- Backpressure and bubbles: the 3-sample batch with sample_valid toggling every cycle, plus a sample presented during DRAIN -> same result as the first batch; the DRAIN sample is not consumed and is accepted in IDLE as the first sample of the next batch.
- Reset mid-batch: assert rst_n=0 after 2 samples, then send batch x={1}, y={1} -> A_flat[0]=0x10000, B_flat[0]=0x10000, with no residue from the discarded samples.
